// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared constants and operation encoding for the counters library.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Direction encodings for up_down inputs
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Limit behaviour encodings for sat_mode inputs
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Per-edge operation selected by the control inputs
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

  // Load wins over count enable; neither means hold
  function automatic op_e op_select(input logic load, input logic en);
    if (load)    return OP_LOAD;
    else if (en) return OP_COUNT;
    else         return OP_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : counter_next_calc
// Purpose  : Combinational next-count and wrap-flag calculator for one
//            enabled counting step within the range 0..limit.
// Revision : 1.0 - initial release
// ============================================================================
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  // One step: out-of-range counts snap to the limit, otherwise step/wrap/saturate
  always_comb begin
    next_o = count_i;
    wrap_o = 1'b0;
    if (count_i > limit_i) begin
      // Limit was lowered underneath us: pull back into range without a pulse
      next_o = limit_i;
    end else if (dir_i == DIR_UP) begin
      if (count_i == limit_i) begin
        if (mode_i == MODE_WRAP) begin
          next_o = C_ZERO;
          wrap_o = 1'b1;
        end else begin
          next_o = limit_i;
        end
      end else begin
        next_o = count_i + C_ONE;
      end
    end else begin
      if (count_i == C_ZERO) begin
        if (mode_i == MODE_WRAP) begin
          next_o = limit_i;
          wrap_o = 1'b1;
        end else begin
          next_o = C_ZERO;
        end
      end else begin
        next_o = count_i - C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Up/down counter with programmable modulus, parallel load,
//            count enable, wrap/saturate select and registered terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             en_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             up_down_in,
  input  logic             sat_mode_in,
  input  logic [WIDTH-1:0] limit_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out,
  output logic             at_max_out,
  output logic             at_min_out
);

  localparam logic [WIDTH-1:0] C_RESET_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;
  logic [WIDTH-1:0] load_val;
  op_e              op;

  counter_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .count_i (count_q),
    .limit_i (limit_in),
    .dir_i   (up_down_in),
    .mode_i  (sat_mode_in),
    .next_o  (step_count),
    .wrap_o  (step_wrap)
  );

  assign op       = op_select(load_in, en_in);
  assign load_val = (d_in > limit_in) ? limit_in : d_in;

  // Select next count and terminal-count flag by operation priority
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    case (op)
      OP_LOAD:  count_d = load_val;
      OP_COUNT: begin
        count_d = step_count;
        tc_d    = step_wrap;
      end
      default:  count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      count_q <= C_RESET_VAL;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_out  = count_q;
  assign tc_out     = tc_q;
  assign at_max_out = (count_q == limit_in);
  assign at_min_out = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_updown_mod
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized traffic against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod;

  localparam int W = 4;

  logic         clk;
  logic         reset_in;
  logic         en_in;
  logic         load_in;
  logic [W-1:0] d_in;
  logic         up_down_in;
  logic         sat_mode_in;
  logic [W-1:0] limit_in;
  logic [W-1:0] count_out;
  logic         tc_out;
  logic         at_max_out;
  logic         at_min_out;

  int total = 0;
  int bad   = 0;

  counter_updown_mod #(
    .WIDTH     (W),
    .RESET_VAL (0)
  ) dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .en_in       (en_in),
    .load_in     (load_in),
    .d_in        (d_in),
    .up_down_in  (up_down_in),
    .sat_mode_in (sat_mode_in),
    .limit_in    (limit_in),
    .count_out   (count_out),
    .tc_out      (tc_out),
    .at_max_out  (at_max_out),
    .at_min_out  (at_min_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       load;
    logic       en;
    logic       up;
    logic       sat;
    logic [3:0] d;
    logic [3:0] lim;
    logic [3:0] e_cnt;
    logic       e_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst_n, input logic load, input logic en,
                              input logic up, input logic sat, input int d,
                              input int lim, input int e_cnt, input logic e_tc);
    vec_t v;
    v.rst_n = rst_n; v.load = load; v.en = en; v.up = up; v.sat = sat;
    v.d = 4'(d); v.lim = 4'(lim); v.e_cnt = 4'(e_cnt); v.e_tc = e_tc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic load, input logic en,
                       input logic up, input logic sat, input logic [3:0] d,
                       input logic [3:0] lim);
    reset_in = rst_n; load_in = load; en_in = en; up_down_in = up;
    sat_mode_in = sat; d_in = d; limit_in = lim;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level reference: plain integer arithmetic over the range 0..lim
  int m_cnt, m_tc;
  function automatic void model_step(input logic rst_n, input logic load, input logic en,
                                     input logic up, input logic sat, input int d, input int lim);
    int n;
    m_tc = 0;
    if (!rst_n) begin
      m_cnt = 0;
    end else if (load) begin
      m_cnt = (d < lim) ? d : lim;
    end else if (en) begin
      if (m_cnt > lim) begin
        m_cnt = lim;
      end else begin
        n = up ? m_cnt + 1 : m_cnt - 1;
        if (n > lim) begin
          m_cnt = sat ? lim : 0;
          m_tc  = sat ? 0 : 1;
        end else if (n < 0) begin
          m_cnt = sat ? 0 : lim;
          m_tc  = sat ? 0 : 1;
        end else begin
          m_cnt = n;
        end
      end
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);

    // ---- directed vector table ----
    add(0, 0, 1, 1, 0, 0, 9, 0, 0);                       // reset held
    for (int r = 0; r < 2; r++) begin                    // two full wrap periods
      for (int i = 1; i <= 9; i++) add(1, 0, 1, 1, 0, 0, 9, i, 0);
      add(1, 0, 1, 1, 0, 0, 9, 0, 1);
    end
    add(1, 0, 0, 1, 0, 0, 9, 0, 0);                       // hold
    add(1, 1, 1, 0, 0, 1, 5, 1, 0);                       // load 1, limit 5
    add(1, 0, 1, 0, 0, 0, 5, 0, 0);                       // down
    add(1, 0, 1, 0, 0, 0, 5, 5, 1);                       // down wrap
    add(1, 0, 1, 0, 0, 0, 5, 4, 0);
    add(1, 1, 0, 0, 1, 0, 5, 0, 0);                       // saturate, load 0
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 1, 0, 5, 0, 0);
    add(1, 1, 1, 1, 0, 12, 9, 9, 0);                      // load clamp
    add(1, 1, 1, 1, 0, 3, 9, 3, 0);
    add(1, 1, 0, 1, 0, 14, 15, 14, 0);                    // full-range limit
    add(1, 0, 1, 1, 0, 0, 15, 15, 0);
    add(1, 0, 1, 1, 0, 0, 15, 0, 1);
    add(1, 1, 0, 1, 0, 5, 0, 0, 0);                       // limit 0, load clamps
    for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 0, 1, i[0], 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].sat,
            vecs[i].d, vecs[i].lim);
      tick();
      check($sformatf("vec%0d cnt", i), 32'(count_out), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d tc", i), 32'(tc_out), 32'(vecs[i].e_tc));
      check($sformatf("vec%0d max", i), 32'(at_max_out), 32'(vecs[i].e_cnt == vecs[i].lim));
      check($sformatf("vec%0d min", i), 32'(at_min_out), 32'(vecs[i].e_cnt == 4'd0));
    end

    // ---- run-time limit drop, up then down ----
    for (int dir = 1; dir >= 0; dir--) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd9);
      tick();
      check("drop load8", 32'(count_out), 32'd8);
      limit_in = 4'd8;
      #1;
      check("drop max at8", 32'(at_max_out), 32'd1);
      limit_in = 4'd4;
      #1;
      check("drop max imm", 32'(at_max_out), 32'd0);
      drive(1'b1, 1'b0, 1'b1, dir[0], 1'b0, 4'd0, 4'd4);
      tick();
      check("drop snap cnt", 32'(count_out), 32'd4);
      check("drop snap tc", 32'(tc_out), 32'd0);
      check("drop snap max", 32'(at_max_out), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4);
    tick();
    check("drop wrap cnt", 32'(count_out), 32'd0);
    check("drop wrap tc", 32'(tc_out), 32'd1);

    // ---- asynchronous reset while a pulse is showing ----
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd9);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
    tick();
    check("arst pre tc", 32'(tc_out), 32'd1);
    #2;
    reset_in = 1'b0;
    #1;
    check("arst cnt", 32'(count_out), 32'd0);
    check("arst tc", 32'(tc_out), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd9);
    reset_in = 1'b0;
    tick();
    check("arst hold cnt", 32'(count_out), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
    tick();
    check("arst release cnt", 32'(count_out), 32'd1);
    check("arst release tc", 32'(tc_out), 32'd0);

    // ---- randomized traffic against the arithmetic model ----
    m_cnt = 1;
    m_tc  = 0;
    begin
      logic [3:0] lim;
      lim = 4'd9;
      for (int c = 0; c < 400; c++) begin
        logic rst_n, load, en, up, sat;
        logic [3:0] d;
        if ($urandom_range(0, 9) == 0) lim = 4'($urandom_range(0, 15));
        rst_n = ($urandom_range(0, 49) != 0);
        load  = ($urandom_range(0, 9) == 0);
        en    = ($urandom_range(0, 9) < 8);
        up    = ($urandom_range(0, 3) != 0);
        sat   = ($urandom_range(0, 4) == 0);
        d     = 4'($urandom_range(0, 15));
        drive(rst_n, load, en, up, sat, d, lim);
        tick();
        model_step(rst_n, load, en, up, sat, int'(d), int'(lim));
        check("rnd cnt", 32'(count_out), 32'(m_cnt));
        check("rnd tc", 32'(tc_out), 32'(m_tc));
        check("rnd max", 32'(at_max_out), 32'(m_cnt == int'(lim)));
        check("rnd min", 32'(at_min_out), 32'(m_cnt == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and selectable wrap/saturate behaviour. It is the general-purpose counter primitive of the counters library. Fixed-width up/down counters are built from it, and it serves as the basis for dividers and event counters. It registers a terminal-count pulse so downstream logic can cascade stages or time events without decoding the count.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (≥ 2).
- RESET_VAL, 0, value loaded into count_out on reset (must be ≤ 2**WIDTH-1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- en_in  input  1  count enable; one step per cycle while high.
- load_in  input  1  synchronous parallel load; overrides en_in.
- d_in  input  WIDTH  load value.
- up_down_in  input  1  direction: 1 = up, 0 = down.
- sat_mode_in  input  1  0 = wrap at limits, 1 = saturate at limits.
- limit_in  input  WIDTH  modulus maximum; the count range is 0..limit_in inclusive.
- count_out  output  WIDTH  registered count.
- tc_out  output  1  registered one-cycle terminal-count pulse.
- at_max_out  output  1  combinational, count_out == limit_in.
- at_min_out  output  1  combinational, count_out == 0.

## Operation

- Reset (reset_in low, asynchronous):
  - count_out = RESET_VAL, tc_out = 0.
  - Reset has priority over everything and holds while asserted.
  - Release is synchronous-clean: the first update occurs on the first rising edge with reset_in high.
- Priority per edge: reset > load > count enable > hold.
- Load (load_in = 1):
  - count_out <= min(d_in, limit_in).
  - tc_out <= 0.
  - en_in, up_down_in and sat_mode_in are ignored that cycle.
- Count (en_in = 1, load_in = 0):
  - Up, count < limit_in: count + 1.
  - Up, count == limit_in: wrap mode gives 0 with tc_out <= 1; saturate mode holds at limit_in with tc_out <= 0.
  - Down, count > 0 and count ≤ limit_in: count − 1.
  - Down, count == 0: wrap mode gives limit_in with tc_out <= 1; saturate mode holds at 0 with tc_out <= 0.
  - count > limit_in (limit_in lowered at run time): the step sets count to limit_in in both directions and both modes, with tc_out <= 0.
- Hold (en_in = 0, load_in = 0): count unchanged, tc_out <= 0.
- limit_in == 0:
  - The counter stays at 0.
  - In wrap mode every enabled step pulses tc_out.
  - In saturate mode tc_out never asserts.
- Arithmetic: all operations are WIDTH-bit unsigned. No intermediate result exceeds WIDTH bits except the comparison, which is WIDTH-bit unsigned. With limit_in = 2**WIDTH−1, wrap is natural modular arithmetic.
- at_max_out / at_min_out:
  - Pure decodes of count_out and limit_in, with no extra latency.
  - Both are high when limit_in == 0 and count == 0.

## Timing

- Count, load, tc_out: one-cycle latency. Inputs sampled at edge N are visible after edge N.
- tc_out is high for exactly the cycle in which count_out shows the wrapped value. Back-to-back wraps produce back-to-back pulses.
- Direction or mode changes take effect on the same edge they are sampled. There is no pipeline and no state besides count_out and tc_out.
- Reset asserted mid-count clears tc_out immediately (asynchronous). No pulse is produced on reset release.
- Combinational flags follow limit_in changes within the same cycle.

## Structure

- Shared package counter_pkg, containing:
  - Direction constants DIR_DOWN = 1'b0 and DIR_UP = 1'b1.
  - Mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
  - Shared across the counters library.
- One sub-module, counter_next_calc: a combinational next-state and tc calculator, parametrised by WIDTH. Inputs are count, limit, direction and mode; outputs are the next count and the wrap flag.
- The top level holds the registers, load/enable priority and flag decodes.

## Test plan

Run with WIDTH = 4 and RESET_VAL = 0.

- Reset and wrap up: pulse reset_in low mid-run, then drive limit_in = 9, en_in = 1, up, wrap mode.
  - count_out = 0 and tc_out = 0 asynchronously during reset.
  - Counts 0..9, then 0 with tc_out = 1 for one cycle; the cycle repeats every 10 edges.
- Down wrap and saturate: limit_in = 5, load 1, count down in wrap mode.
  - Sequence 0, 5 with tc_out pulse, 4.
  - Switch to saturate and load 0, then count down: holds at 0, at_min_out = 1, tc_out stays 0.
- Load priority and clamp:
  - load_in = 1 with en_in = 1 and d_in = 12 while limit_in = 9 gives count_out = 9 and tc_out = 0.
  - d_in = 3 gives 3.
- Run-time limit drop: count at 8, limit_in changed to 4.
  - at_max_out = 0 immediately.
  - The next enabled step (up or down) gives count_out = 4 with no tc_out. The step after (up, wrap) gives 0 with a tc_out pulse.
- Edge limits:
  - limit_in = 15, up, wrap: 15 goes to 0 with a tc pulse.
  - limit_in = 0, wrap, en high: count stays 0 and tc_out high every cycle.
  - Same with saturate: tc_out stays 0.
